// File: rtl/seq_div_unit_if.sv
// ----------------------------------------------------------------------------
// seq_div_unit_if : divide request/response bundle between the ALU and the
//                   sequential divider.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface seq_div_unit_if #(
  parameter int WIDTH = 32
);
  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

`default_nettype wire

// File: rtl/seq_div_unit.sv
// ----------------------------------------------------------------------------
// seq_div_unit : multi-cycle restoring divider, {remainder, quotient} result.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seq_div_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic        clk,
  input  wire logic        rst,
  seq_div_unit_if.slave    bus
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_END  = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   dq;      // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0]   prem;
  logic [WIDTH-1:0]   dvs;
  logic               neg_q;
  logic               neg_r;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     shifted;
  logic               fits;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   next_prem;
  logic [WIDTH-1:0]   next_dq;
  logic [WIDTH-1:0]   quot_fin;
  logic [WIDTH-1:0]   rem_fin;

  always_comb begin
    a_neg   = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    b_neg   = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    a_mag   = a_neg ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
    b_mag   = b_neg ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;

    // Partial remainder stays below the divisor, so a WIDTH-bit difference is exact when it fits.
    shifted   = {prem, dq[WIDTH-1]};
    fits      = (shifted >= {1'b0, dvs});
    diff      = shifted[WIDTH-1:0] - dvs;
    next_prem = fits ? diff : shifted[WIDTH-1:0];
    next_dq   = {dq[WIDTH-2:0], fits};

    quot_fin  = neg_q ? (~next_dq + 1'b1)   : next_dq;
    rem_fin   = neg_r ? (~next_prem + 1'b1) : next_prem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      dq     <= '0;
      prem   <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      ready  <= 1'b0;
      result <= '0;
    end else if (bus.annul_i) begin
      state  <= S_IDLE;
      cnt    <= '0;
      ready  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ready  <= 1'b0;
          result <= '0;
          if (bus.start_i) begin
            if (bus.opdata2_i == '0) begin
              state <= S_END;
              ready <= 1'b1;
            end else begin
              state <= S_ON;
              cnt   <= '0;
              dq    <= a_mag;
              dvs   <= b_mag;
              prem  <= '0;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
            end
          end
        end
        S_ON: begin
          dq   <= next_dq;
          prem <= next_prem;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            result <= {rem_fin, quot_fin};
            ready  <= 1'b1;
            state  <= S_END;
          end
        end
        S_END: begin
          if (!bus.start_i) begin
            state  <= S_IDLE;
            ready  <= 1'b0;
            result <= '0;
          end
        end
        default: begin
          state  <= S_IDLE;
          ready  <= 1'b0;
          result <= '0;
        end
      endcase
    end
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;

endmodule

`default_nettype wire

// File: doc/seq_div_unit.md
# seq_div_unit

Multi-cycle 32-bit integer divider serving the execute-stage ALU through a level start/ready handshake. It accepts a dividend, divisor and signedness flag, runs 32 restoring-division iterations, and returns `{remainder, quotient}` packed for direct write into HI/LO. It is the responder side of the ALU's divide request: the ALU raises `start_i` and stalls until `ready_o` is high.

## Interface

Parameters:
- `WIDTH`, 32, operand width; quotient and remainder are each `WIDTH` bits.

Ports:
- `clk`, input, 1, the only clock; all state updates on rising edge.
- `rst`, input, 1, synchronous, active-high reset.
- `signed_div_i`, input, 1, 1 = signed (DIV), 0 = unsigned (DIVU); sampled only at acceptance.
- `opdata1_i`, input, 32, dividend; sampled only at acceptance.
- `opdata2_i`, input, 32, divisor; sampled only at acceptance.
- `start_i`, input, 1, level request; the initiator holds it high until it sees `ready_o`.
- `annul_i`, input, 1, abort the current operation (exception/flush).
- `result_o`, output, 64, `[63:32]` remainder (HI), `[31:0]` quotient (LO).
- `ready_o`, output, 1, `result_o` valid.

## Operation

- States: IDLE, ON, END.
- Priority on every edge: `rst` > `annul_i` > normal transitions.
- IDLE: `ready_o`=0, `result_o`=0. If `start_i`=1 and `annul_i`=0:
  - divisor == 0 -> go directly to END with `result_o`=64'h0.
  - otherwise latch operands, go to ON, iteration counter = 0.
  - In signed mode, replace each negative operand with its two's-complement magnitude. 0x80000000 maps to unsigned 0x80000000.
  - Record `neg_q` = sign(dividend) XOR sign(divisor) and `neg_r` = sign(dividend). Both are 0 in unsigned mode.
- ON: one restoring step per edge:
  - Shift the next dividend bit, MSB first, into the 33-bit partial remainder.
  - Trial-subtract the divisor magnitude.
  - If the difference is non-negative, keep it and shift 1 into the quotient; otherwise shift 0 into the quotient.
  - On the edge performing step 32 (counter == 31): apply two's-complement negation to the quotient if `neg_q` and to the remainder if `neg_r`, register the result into `result_o`, and go to END.
- END: `ready_o`=1; `result_o` is held stable. Stay while `start_i`=1. When `start_i`=0, go to IDLE and clear `ready_o` and `result_o` on that edge.
- `annul_i`=1 in any state: next state IDLE, `ready_o`=0, `result_o`=0, counter cleared. Any in-flight operation is discarded.
- Operand changes after acceptance have no effect.
- Signed INT_MIN / -1: quotient 0x80000000 (wraps), remainder 0. No overflow flag.
- Remainder sign follows the dividend; quotient truncates toward zero (MIPS semantics).

## Timing

- Reset values: state IDLE, `ready_o`=0, `result_o`=64'h0, counter 0.
- Edge E0 is the IDLE edge that samples `start_i`=1.
- Normal latency: steps occur on E1..E32. `ready_o` and `result_o` are valid from after E32, i.e. 32 clocks after acceptance.
- Divide-by-zero latency: `ready_o`=1 and `result_o`=0 after E0, i.e. 1 clock.
- `ready_o` stays high until the first edge that samples `start_i`=0 in END. It falls after that edge.
- Earliest next acceptance is the following edge. There is always at least one IDLE cycle between operations.
- `start_i` deasserted during ON with `annul_i`=0 is ignored: the operation completes, and END then exits on the next edge because `start_i` is already 0.
- `annul_i` and `start_i` both high in IDLE: not accepted; remain IDLE.
- `rst` mid-operation: IDLE on that edge with all outputs zero, regardless of other inputs.

## Test plan

- Unsigned 100/7, `start_i` held: `ready_o` rises exactly 32 clocks after acceptance with `result_o`=64'h00000002_0000000E. Drop `start_i` -> `ready_o`=0 and `result_o`=0 one clock later.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002): `result_o`=64'hFFFFFFFF_FFFFFFFD. Then signed 7/-2 -> 64'h00000001_FFFFFFFD. Then unsigned 0xFFFFFFF9/2 -> 64'h00000001_7FFFFFFC.
- Boundary values:
  - Signed 0x80000000 / 0xFFFFFFFF -> 64'h00000000_80000000.
  - Unsigned 0xFFFFFFFF / 1 -> 64'h00000000_FFFFFFFF.
  - 5/9 -> 64'h00000005_00000000.
- Divisor 0, both modes: `ready_o`=1 one clock after acceptance with `result_o`=0. Holds while `start_i`=1.
- Annul and reset:
  - `annul_i` pulsed at step 10: `ready_o` stays 0 and state returns to IDLE. A new start 1 clock later (13/4) completes in 32 clocks with 64'h00000001_00000003.
  - `rst` pulsed mid-ON gives the same recovery.
- Operands changed every cycle during ON, and `start_i` dropped at step 5: result still reflects the latched operands. `ready_o` pulses exactly one cycle, then IDLE.
